// File: rtl/decode_execute_skid.sv
// Two-entry skid buffer between decode and execute. Passes the decoded bundle
// uninterpreted, breaks the ready path, supports flush and counts stall cycles.
module decode_execute_skid #(
   parameter int WORD_WIDTH           = 32,
   parameter int REGISTER_INDEX_WIDTH = 5,
   parameter int OFFSET_SIZE          = 12,
   parameter int BUNDLE_WIDTH         = 3*WORD_WIDTH + 3*REGISTER_INDEX_WIDTH + OFFSET_SIZE + 9
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BUNDLE_WIDTH-1:0] bundle_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [BUNDLE_WIDTH-1:0] bundle_out,
   output logic [1:0]              occupancy,
   output logic [15:0]             stall_cycles
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [BUNDLE_WIDTH-1:0] main_q;
   logic [BUNDLE_WIDTH-1:0] skid_q;
   logic                    main_v;
   logic                    skid_v;
   logic                    accept;
   logic                    fire;
   logic                    load_main_in;
   logic                    load_main_skid;
   logic                    load_skid;

   // The state encoding doubles as the occupancy count.
   assign main_v     = (state != EMPTY);
   assign skid_v     = (state == FULL);
   assign in_ready   = rst & ~skid_v;
   assign out_valid  = main_v;
   assign bundle_out = main_q;
   assign occupancy  = state;

   assign accept = in_valid & in_ready & ~flush;
   assign fire   = main_v & out_ready;

   always_comb begin
      state_next     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               load_main_in = 1'b1;
               state_next   = ONE;
            end
         end
         ONE: begin
            if (accept && fire) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               load_skid  = 1'b1;
               state_next = FULL;
            end else if (fire) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            if (fire) begin
               load_main_skid = 1'b1;
               state_next     = ONE;
            end
         end
         default: state_next = EMPTY;
      endcase
      // Flush wins over every transition; data registers may keep stale values.
      if (flush) begin
         state_next = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state <= state_next;
         if (load_main_in) begin
            main_q <= bundle_in;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= bundle_in;
         end
      end
   end

   // Stall counter survives flush; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cycles <= '0;
      end else if (main_v && !out_ready && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end

endmodule

// File: tb/tb_decode_execute_skid.sv
// Self-checking bench for decode_execute_skid: FIFO scoreboard model checked
// every cycle, a hand-computed back-pressure table, and corner-case sequences.
module tb_decode_execute_skid;

   localparam int BW = 132;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] bundle_in;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] bundle_out;
   logic [1:0]    occupancy;
   logic [15:0]   stall_cycles;

   int            checks;
   int            failures;
   logic [BW-1:0] sb_q[$];
   logic [15:0]   exp_stall;
   logic          exp_zero;

   typedef struct {
      logic        in_valid;
      logic        out_ready;
      logic        flush;
      logic [31:0] rm0;
      logic [1:0]  exp_occ;
      logic        exp_in_ready;
      logic        exp_out_valid;
      logic [15:0] exp_stall;
   } vec_t;

   vec_t vecs[6];

   decode_execute_skid dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .bundle_in    (bundle_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .bundle_out   (bundle_out),
      .occupancy    (occupancy),
      .stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Deterministic bundle derived from rm0 so a held offer stays identical.
   function automatic logic [BW-1:0] mk(input logic [31:0] rm0);
      logic [127:0] t;
      t = {~rm0, rm0 * 32'd3, rm0 ^ 32'hDEADBEEF, rm0 + 32'd7};
      return {rm0, t[99:0]};
   endfunction

   task automatic compareField(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic checkOutput();
      compareField("occupancy", BW'(occupancy), BW'(sb_q.size()));
      compareField("out_valid", BW'(out_valid), BW'(sb_q.size() > 0));
      compareField("in_ready", BW'(in_ready), BW'(rst && (sb_q.size() < 2)));
      compareField("stall_cycles", BW'(stall_cycles), BW'(exp_stall));
      if (sb_q.size() > 0) begin
         compareField("bundle_out", bundle_out, sb_q[0]);
      end else if (exp_zero) begin
         compareField("bundle_out_reset", bundle_out, '0);
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic ordy, input logic fl,
                                input logic rs, input logic [31:0] rm0);
      logic          m_accept;
      logic          m_fire;
      logic [BW-1:0] data;
      data      = mk(rm0);
      in_valid  = iv;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      bundle_in = data;
      m_accept  = rs && iv && !fl && (sb_q.size() < 2);
      m_fire    = rs && (sb_q.size() > 0) && ordy;
      if (!rs) begin
         exp_stall = '0;
      end else if ((sb_q.size() > 0) && !ordy && (exp_stall != 16'hFFFF)) begin
         exp_stall = exp_stall + 16'd1;
      end
      @(posedge clk);
      #1;
      if (!rs) begin
         sb_q.delete();
         exp_zero = 1'b1;
      end else begin
         if (m_fire) begin
            void'(sb_q.pop_front());
         end
         if (fl) begin
            sb_q.delete();
         end else if (m_accept) begin
            sb_q.push_back(data);
            exp_zero = 1'b0;
         end
      end
      checkOutput();
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      exp_stall = '0;
      exp_zero  = 1'b1;
      rst       = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      bundle_in = '0;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_00A0, 2'd1, 1'b1, 1'b1, 16'd0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_00B0, 2'd2, 1'b0, 1'b1, 16'd1};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_00C0, 2'd2, 1'b0, 1'b1, 16'd2};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_00C0, 2'd1, 1'b1, 1'b1, 16'd2};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_00C0, 2'd1, 1'b1, 1'b1, 16'd2};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'd0, 1'b1, 1'b0, 16'd2};

      // Reset held with decode offering, then release.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0055);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      compareField("in_ready_after_release", BW'(in_ready), BW'(1));

      // Streaming at full bandwidth.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h100 + 32'(4 * i));
         compareField("stream_rm0", BW'(bundle_out[BW-1:BW-32]), BW'(32'h100 + 32'(4 * i)));
         compareField("stream_occ", BW'(occupancy), BW'(1));
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);

      // Back-pressure table: A, B accepted, C held, then drained in order.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].in_valid, vecs[i].out_ready, vecs[i].flush, 1'b1, vecs[i].rm0);
         compareField("bp_occ", BW'(occupancy), BW'(vecs[i].exp_occ));
         compareField("bp_in_ready", BW'(in_ready), BW'(vecs[i].exp_in_ready));
         compareField("bp_out_valid", BW'(out_valid), BW'(vecs[i].exp_out_valid));
         compareField("bp_stall", BW'(stall_cycles), BW'(vecs[i].exp_stall));
         if (vecs[i].exp_out_valid && i < 3) begin
            compareField("bp_rm0_head", BW'(bundle_out[BW-1:BW-32]), BW'(32'h0000_00A0));
         end
      end

      // Flush while FULL with a fire and a new offer in the same cycle.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h204);
      compareField("pre_flush_occ", BW'(occupancy), BW'(2));
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h2FF);
      compareField("post_flush_occ", BW'(occupancy), BW'(0));
      compareField("post_flush_valid", BW'(out_valid), BW'(0));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h300);
      compareField("after_flush_rm0", BW'(bundle_out[BW-1:BW-32]), BW'(32'h300));

      // Stall counter saturation, then flush must not clear it.
      for (int i = 0; i < 65540; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      end
      compareField("stall_saturated", BW'(stall_cycles), BW'(16'hFFFF));
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      compareField("stall_after_flush", BW'(stall_cycles), BW'(16'hFFFF));

      // Reset mid-operation drops both entries.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h400);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h404);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h4FF);
      compareField("mid_reset_occ", BW'(occupancy), BW'(0));
      compareField("mid_reset_valid", BW'(out_valid), BW'(0));
      compareField("mid_reset_stall", BW'(stall_cycles), BW'(0));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h500);
      compareField("first_after_reset", BW'(bundle_out[BW-1:BW-32]), BW'(32'h500));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
